lfsr_sched: RTL and testbench

- Scheduler and sequencer for the 16-bit Galois LFSR (`lfsr`).
- Shares one LFSR between two requesters using round-robin arbitration. Owns the LFSR state register and feeds it back through the LFSR's `lfsr_in`.
- Steps the LFSR STEPS times per delivered word for decorrelation, then returns the word with a one-cycle done strobe.
- Accepts runtime reseeding; a zero seed is never loaded.

---
 rtl/lfsr_sched.sv | 184 ++++++++++++++++++
 tb/tb_lfsr_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sched.sv
// rtl/lfsr_sched.sv - round-robin scheduler and sequencer for a shared 16-bit Galois LFSR
//
// Purpose:
//   Arbitrates two requesters onto one external LFSR. This block owns the
//   LFSR state register; the LFSR itself is a registered step function.
//   The block steps the LFSR STEPS times per delivered word, then returns
//   the word together with a one-cycle done strobe. Runtime reseeding is
//   supported, and a zero seed is replaced by SEED.
//
// Optional build macro:
//   LFSR_SCHED_STATS_EN - adds per-requester saturating service counters
//                         gnt_cnt0/gnt_cnt1 with a synchronous clear stats_clr.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   seed_load  in   one-cycle reseed request
//   seed_val   in   16-bit seed, sampled with seed_load
//   req        in   2-bit level request, one bit per requester
//   gnt        out  one-hot grant, held for the whole service
//   done       out  one-cycle completion strobe to the served requester
//   rnd_data   out  delivered word, held until the next done
//   busy       out  FSM is not in IDLE
//   lfsr_in    out  to LFSR input; always the state register
//   lfsr_en    out  to LFSR enable; high only in STEP
//   lfsr_out   in   from LFSR output, one-cycle latency
//   stats_clr  in   (stats build) synchronous clear of both counters
//   gnt_cnt0/1 out  (stats build) completed services per requester

module lfsr_sched #(
    parameter int          STEPS = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed_val,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [15:0] rnd_data,
    output logic        busy,
    output logic [15:0] lfsr_in,
    output logic        lfsr_en,
    input  logic [15:0] lfsr_out
`ifdef LFSR_SCHED_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
`endif
);

    localparam logic [3:0] STEPS_C = 4'(STEPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_CAP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] seed_q, seed_d;
    logic        pend_q, pend_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [15:0] rnd_q, rnd_d;
    logic        last_q, last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            seed_q  <= SEED;
            pend_q  <= 1'b0;
            cnt_q   <= 4'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rnd_q   <= 16'h0000;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        rnd_d   = rnd_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                // A seed arriving in this very cycle also wins over requests,
                // so reseed always precedes the grant it coincides with.
                if (pend_q || seed_load) begin
                    state_d = S_LOAD;
                end else if (req != 2'b00) begin
                    if (req == 2'b01)      gnt_d = 2'b01;
                    else if (req == 2'b10) gnt_d = 2'b10;
                    else                   gnt_d = last_q ? 2'b01 : 2'b10;
                    cnt_d   = STEPS_C;
                    state_d = S_STEP;
                end
            end
            S_LOAD: begin
                lfsr_d  = seed_q;
                state_d = S_IDLE;
            end
            S_STEP: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                lfsr_d  = lfsr_out;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_DONE : S_STEP;
            end
            S_DONE: begin
                done_d  = gnt_q;
                rnd_d   = lfsr_q;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pulse landing on the LOAD cycle keeps the request pending so the
        // newer seed is applied on a following IDLE.
        if (seed_load) begin
            seed_d = (seed_val == 16'h0000) ? SEED : seed_val;
            pend_d = 1'b1;
        end else if (state_q == S_LOAD) begin
            pend_d = 1'b0;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rnd_data = rnd_q;
    assign busy     = (state_q != S_IDLE);
    assign lfsr_in  = lfsr_q;
    assign lfsr_en  = (state_q == S_STEP);

`ifdef LFSR_SCHED_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else if (stats_clr) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (done_d[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (done_d[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_lfsr_sched.sv
// tb/tb_lfsr_sched.sv - directed self-checking bench for lfsr_sched

module tb_lfsr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        sl_a = 1'b0, sl_b = 1'b0;
    logic [15:0] sv_a = '0, sv_b = '0;
    logic [1:0]  req_a = '0, req_b = '0;
    logic [1:0]  gnt_a, gnt_b, done_a, done_b;
    logic [15:0] rnd_a, rnd_b, li_a, li_b, lo_a, lo_b;
    logic        busy_a, busy_b, en_a, en_b;
`ifdef LFSR_SCHED_STATS_EN
    logic        clr = 1'b0;
    logic [15:0] gc0_a, gc1_a, gc0_b, gc1_b;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] ma, mb;
    int c0 = 0, c1 = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000);
    endfunction

    function automatic logic [15:0] word(input logic [15:0] s, input int n);
        logic [15:0] t = s;
        for (int i = 0; i < n; i++) t = step(t);
        return t;
    endfunction

    // External registered LFSR models, one per DUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_a <= '0;
            lo_b <= '0;
        end else begin
            if (en_a) lo_a <= step(li_a);
            if (en_b) lo_b <= step(li_b);
        end
    end

    lfsr_sched #(.STEPS(4), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst_n), .seed_load(sl_a), .seed_val(sv_a), .req(req_a),
        .gnt(gnt_a), .done(done_a), .rnd_data(rnd_a), .busy(busy_a),
        .lfsr_in(li_a), .lfsr_en(en_a), .lfsr_out(lo_a)
`ifdef LFSR_SCHED_STATS_EN
        , .stats_clr(clr), .gnt_cnt0(gc0_a), .gnt_cnt1(gc1_a)
`endif
    );

    lfsr_sched #(.STEPS(1), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst_n), .seed_load(sl_b), .seed_val(sv_b), .req(req_b),
        .gnt(gnt_b), .done(done_b), .rnd_data(rnd_b), .busy(busy_b),
        .lfsr_in(li_b), .lfsr_en(en_b), .lfsr_out(lo_b)
`ifdef LFSR_SCHED_STATS_EN
        , .stats_clr(clr), .gnt_cnt0(gc0_b), .gnt_cnt1(gc1_b)
`endif
    );

    // Runs one service; must be called at a negedge, returns at a negedge.
    // lat = edges from the sampling edge until done is visible.
    task automatic svc(input int sel, input logic [1:0] r, input bit keep,
                       input bit sl, input logic [15:0] sv,
                       input bit msl, input logic [15:0] msv,
                       output int lat, output logic [1:0] g, output logic [1:0] d,
                       output logic [15:0] data, output int ens);
        if (sel == 0) begin req_a = r; sl_a = sl; sv_a = sv; end
        else          begin req_b = r; sl_b = sl; sv_b = sv; end
        @(posedge clk);
        #1 sl_a = 1'b0; sl_b = 1'b0;
        lat = 0; ens = 0; g = '0; d = '0; data = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (g == 2'b00) g = (sel == 0) ? gnt_a : gnt_b;
            if ((sel == 0) ? en_a : en_b) ens++;
            if (k == 1 && msl) begin
                if (sel == 0) begin sl_a = 1'b1; sv_a = msv; end
                else          begin sl_b = 1'b1; sv_b = msv; end
            end else if (k == 2) begin
                sl_a = 1'b0; sl_b = 1'b0;
            end
            if (((sel == 0) ? done_a : done_b) != 2'b00) begin
                d = (sel == 0) ? done_a : done_b;
                data = (sel == 0) ? rnd_a : rnd_b;
                break;
            end
            lat++;
        end
        if (sel == 0) begin
            if (d[0]) c0++;
            if (d[1]) c1++;
        end
        if (!keep) begin
            if (sel == 0) req_a = '0; else req_b = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_a = '0; req_b = '0; sl_a = 1'b0; sl_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ma = 16'hACE1; mb = 16'hACE1; c0 = 0; c1 = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (gnt_a !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt_a); end
        tests++; if (done_a !== 2'b00) begin fails++; $display("FAIL reset_done: got %b want 00", done_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        tests++; if (en_a !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", en_a); end
        tests++; if (rnd_a !== 16'h0000) begin fails++; $display("FAIL reset_rnd: got %h want 0000", rnd_a); end
        tests++; if (li_a !== 16'hACE1) begin fails++; $display("FAIL reset_state: got %h want ace1", li_a); end
        do_reset();
    endtask

    task automatic test_single();
        int lat, ens; logic [1:0] g, d; logic [15:0] data, exp;
        svc(0, 2'b01, 0, 0, '0, 0, '0, lat, g, d, data, ens);
        exp = word(ma, 4); ma = exp;
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", g); end
        tests++; if (d !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", d); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL single_lat: got %0d want 9", lat); end
        tests++; if (ens !== 4) begin fails++; $display("FAIL single_en_cycles: got %0d want 4", ens); end
        tests++; if (data !== 16'hCF22) begin fails++; $display("FAIL single_word: got %h want cf22", data); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b want 0", busy_a); end
        @(negedge clk);
        tests++; if (done_a !== 2'b00) begin fails++; $display("FAIL single_done_strobe: got %b want 00", done_a); end
        tests++; if (rnd_a !== 16'hCF22) begin fails++; $display("FAIL single_word_held: got %h want cf22", rnd_a); end
        svc(0, 2'b01, 0, 0, '0, 0, '0, lat, g, d, data, ens);
        exp = word(ma, 4); ma = exp;
        tests++; if (data !== exp) begin fails++; $display("FAIL second_word: got %h want %h", data, exp); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL second_lat: got %0d want 9", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, ens; logic [1:0] g, d; logic [15:0] data, exp, prev;
        logic [1:0] want;
        do_reset();
        prev = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            svc(0, 2'b11, (i < 3), 0, '0, 0, '0, lat, g, d, data, ens);
            exp = word(ma, 4); ma = exp;
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (g !== want) begin fails++; $display("FAIL b2b_gnt%0d: got %b want %b", i, g, want); end
            tests++; if (d !== want) begin fails++; $display("FAIL b2b_done%0d: got %b want %b", i, d, want); end
            tests++; if (data !== exp) begin fails++; $display("FAIL b2b_word%0d: got %h want %h", i, data, exp); end
            tests++; if (lat !== 9) begin fails++; $display("FAIL b2b_lat%0d: got %0d want 9", i, lat); end
            tests++; if (data === prev) begin fails++; $display("FAIL b2b_distinct%0d: got %h want not %h", i, data, prev); end
            prev = data;
        end
    endtask

    task automatic test_seed_steps1();
        int lat, ens; logic [1:0] g, d; logic [15:0] data;
        svc(1, 2'b10, 0, 1, 16'h8000, 0, '0, lat, g, d, data, ens);
        mb = 16'h002D;
        tests++; if (d !== 2'b10) begin fails++; $display("FAIL seed1_done: got %b want 10", d); end
        tests++; if (data !== 16'h002D) begin fails++; $display("FAIL seed1_word: got %h want 002d", data); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL seed1_lat: got %0d want 5", lat); end
        tests++; if (ens !== 1) begin fails++; $display("FAIL seed1_en_cycles: got %0d want 1", ens); end
    endtask

    task automatic test_seed_zero();
        int lat, ens; logic [1:0] g, d; logic [15:0] data;
        svc(0, 2'b01, 0, 1, 16'h0000, 0, '0, lat, g, d, data, ens);
        ma = 16'hCF22;
        tests++; if (data !== 16'hCF22) begin fails++; $display("FAIL seed0_word: got %h want cf22", data); end
        tests++; if (lat !== 11) begin fails++; $display("FAIL seed0_lat: got %0d want 11", lat); end
    endtask

    task automatic test_seed_mid();
        int lat, ens; logic [1:0] g, d; logic [15:0] data, exp;
        svc(0, 2'b10, 0, 0, '0, 1, 16'h1234, lat, g, d, data, ens);
        exp = word(ma, 4);
        tests++; if (data !== exp) begin fails++; $display("FAIL mid_seed_old_word: got %h want %h", data, exp); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL mid_seed_lat: got %0d want 9", lat); end
        svc(0, 2'b10, 0, 0, '0, 0, '0, lat, g, d, data, ens);
        exp = word(16'h1234, 4); ma = exp;
        tests++; if (data !== exp) begin fails++; $display("FAIL mid_seed_new_word: got %h want %h", data, exp); end
        tests++; if (lat !== 11) begin fails++; $display("FAIL mid_seed_deferred_lat: got %0d want 11", lat); end
    endtask

    task automatic test_reset_mid();
        int lat, ens; logic [1:0] g, d; logic [15:0] data;
        req_a = 2'b01;
        @(posedge clk);
        @(negedge clk);
        tests++; if (en_a !== 1'b1) begin fails++; $display("FAIL rmid_in_step: got %b want 1", en_a); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (gnt_a !== 2'b00) begin fails++; $display("FAIL rmid_gnt: got %b want 00", gnt_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
        tests++; if (en_a !== 1'b0) begin fails++; $display("FAIL rmid_en: got %b want 0", en_a); end
        tests++; if (done_a !== 2'b00) begin fails++; $display("FAIL rmid_done: got %b want 00", done_a); end
        tests++; if (rnd_a !== 16'h0000) begin fails++; $display("FAIL rmid_rnd: got %h want 0000", rnd_a); end
        tests++; if (li_a !== 16'hACE1) begin fails++; $display("FAIL rmid_state: got %h want ace1", li_a); end
        req_a = '0;
        @(negedge clk);
        rst_n = 1'b1; ma = 16'hACE1; c0 = 0; c1 = 0;
        svc(0, 2'b01, 0, 0, '0, 0, '0, lat, g, d, data, ens);
        ma = data;
        tests++; if (data !== 16'hCF22) begin fails++; $display("FAIL rmid_first_word: got %h want cf22", data); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL rmid_lat: got %0d want 9", lat); end
    endtask

`ifdef LFSR_SCHED_STATS_EN
    task automatic test_stats();
        int lat, ens; logic [1:0] g, d; logic [15:0] data;
        svc(0, 2'b10, 0, 0, '0, 0, '0, lat, g, d, data, ens);
        tests++; if (gc0_a !== 16'(c0)) begin fails++; $display("FAIL stats_cnt0: got %0d want %0d", gc0_a, c0); end
        tests++; if (gc1_a !== 16'(c1)) begin fails++; $display("FAIL stats_cnt1: got %0d want %0d", gc1_a, c1); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests++; if (gc0_a !== 16'h0000) begin fails++; $display("FAIL stats_clr0: got %0d want 0", gc0_a); end
        tests++; if (gc1_a !== 16'h0000) begin fails++; $display("FAIL stats_clr1: got %0d want 0", gc1_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_seed_steps1();
        test_seed_zero();
        test_seed_mid();
        test_reset_mid();
`ifdef LFSR_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
